fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Sequences the instruction fetch stage: owns the program counter, drives the instruction memory address and captures the returned word into the IF/ID pipeline register.
- Arbitrates between normal increment, downstream stall, hazard stall, branch redirect and halt.
- Sits between the execute-stage branch resolution, the hazard unit and the decode stage. Replaces the free-running PC with a controlled one.

Parameters:
- ADDR_W, 8, PC and instruction memory address width.
- INSTR_W, 16, instruction word width.
- PC_STEP, 1, PC increment per fetched instruction (word addressed).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  leave IDLE and start fetching; sampled only in IDLE.
- br_valid  in  1  redirect request from execute stage.
- br_target  in  ADDR_W  redirect target PC.
- stall_req  in  1  hazard-unit stall; hold PC and IF/ID.
- halt_req  in  1  stop fetching after the current cycle.
- id_ready  in  1  decode accepts IF/ID this cycle.
- imem_addr  out  ADDR_W  combinational copy of pc_q.
- imem_data  in  INSTR_W  combinational instruction memory read data for imem_addr.
- ifid_valid  out  1  IF/ID holds a valid instruction.
- ifid_out  out  ADDR_W+INSTR_W  packed {instruction, pc}; instruction in the upper INSTR_W bits, pc in the lower ADDR_W bits.
- state_o  out  3  FSM state for debug: IDLE=0, FETCH=1, STALL=2, FLUSH=3, HALT=4.
- perf_stall_cnt  out  16  stall-cycle counter (see Optional Feature).
- perf_flush_cnt  out  16  redirect counter (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): pc_q=0, ifid_valid=0, ifid_out=0, state=IDLE, perf counters=0. Reset mid-operation discards any in-flight IF/ID content immediately.
- hold = stall_req | (ifid_valid & ~id_ready).
- Priority per edge: br_valid > hold > halt_req > normal fetch. br_valid is honoured in every state except IDLE, where it is ignored.
- IDLE: ifid_valid=0 and pc held. Goes to FETCH on fetch_en=1; the first capture happens on the following edge.
- FETCH, no event: ifid_out <= {imem_data, pc_q}, ifid_valid <= 1, pc_q <= pc_q + PC_STEP. Latency from PC to IF/ID output is 1 cycle.
- FETCH with hold: go to STALL. pc_q and ifid_out are unchanged; the word at pc_q is not consumed.
- STALL: stays while hold=1. When hold drops, returns to FETCH and does a normal fetch that same edge.
- Redirect (any non-IDLE state): pc_q <= br_target, ifid_valid <= 0, go to FLUSH. This flushes the wrong-path word, even if hold is set.
- FLUSH: exactly one cycle with ifid_valid=0, then returns to FETCH. On that edge it fetches normally from br_target, unless hold (go to STALL) or halt_req (go to HALT). A br_valid during FLUSH re-redirects and stays in FLUSH.
- halt_req in FETCH without hold: go to HALT without capturing. ifid_valid goes to 0 once id_ready consumes the last word; pc_q is held. HALT exits only via br_valid (to FLUSH) or reset.
- PC arithmetic is modulo 2^ADDR_W: 0xFF+1 wraps to 0x00 with no flag and no stall.
- The IF/ID register is never overwritten while ifid_valid=1 and id_ready=0.

Optional Feature:
- Macro: FETCH_SEQ_PERF_EN.
- Defined: perf_stall_cnt increments on each cycle in STALL. perf_flush_cnt increments on each accepted redirect. Both saturate at 0xFFFF and clear on reset.
- Undefined: both ports remain and are tied to 0, with no counter logic.

Test Plan:
- Reset then fetch_en=1, id_ready=1, memory[0..2]=0x5012,0x5052,0x5016 -> ifid_out = 0x501200, 0x505201, 0x501602 on consecutive cycles; state_o=1.
- id_ready=0 for 3 cycles while valid at pc=2 -> ifid_out held at 0x501602, pc_q held at 3, state_o=2. Resume -> next word from pc 3, no instruction lost or duplicated.
- br_valid=1, br_target=0x04 together with stall_req=1 -> one bubble cycle (ifid_valid=0, state_o=3), then ifid_out = {mem[4], 0x04}.
- pc_q=0xFF, normal fetch -> ifid pc field=0xFF, next pc_q=0x00.
- halt_req=1 -> state_o=4, pc frozen for 10 cycles. Then br_valid with target 0x10 -> FLUSH, then fetch from 0x10.
- rst_n pulsed low mid-stall -> outputs return to reset values immediately, without waiting for a clock edge. With FETCH_SEQ_PERF_EN defined, perf_stall_cnt equals the stall cycles counted before reset, then 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Instruction fetch sequencer. It owns the program counter, drives the
//   instruction memory address and captures the returned word into the
//   IF/ID pipeline register. Each edge is resolved in priority order:
//   branch redirect, then hold (hazard stall or decode back-pressure), then
//   halt, then a normal fetch.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   fetch_en       start fetching (sampled only in IDLE)
//   br_valid       redirect request from execute (ignored in IDLE)
//   br_target      redirect target PC
//   stall_req      hazard-unit stall
//   halt_req       stop fetching
//   id_ready       decode accepts IF/ID this cycle
//   imem_addr      instruction memory address (copy of the PC)
//   imem_data      combinational instruction memory read data
//   ifid_valid     IF/ID holds a valid instruction
//   ifid_out       packed {instruction, pc}
//   state_o        FSM state: IDLE=0 FETCH=1 STALL=2 FLUSH=3 HALT=4
//   perf_stall_cnt saturating count of cycles spent in STALL
//   perf_flush_cnt saturating count of accepted redirects
//
// Optional feature macro: FETCH_SEQ_PERF_EN
//   Defined   -> both perf counters are implemented.
//   Undefined -> both perf ports are tied to zero.
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int PC_STEP = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fetch_en,
  input  logic                      br_valid,
  input  logic [ADDR_W-1:0]         br_target,
  input  logic                      stall_req,
  input  logic                      halt_req,
  input  logic                      id_ready,
  output logic [ADDR_W-1:0]         imem_addr,
  input  logic [INSTR_W-1:0]        imem_data,
  output logic                      ifid_valid,
  output logic [ADDR_W+INSTR_W-1:0] ifid_out,
  output logic [2:0]                state_o,
  output logic [15:0]               perf_stall_cnt,
  output logic [15:0]               perf_flush_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_STALL = 3'd2,
    S_FLUSH = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [ADDR_W-1:0]           r_pc;
  logic                        r_valid;
  logic [ADDR_W+INSTR_W-1:0]   r_ifid;

  logic                        w_hold;
  logic                        w_redirect;
  logic                        w_capture;
  logic                        w_drop;

  // A valid IF/ID word that decode refuses stalls fetch just like a hazard.
  assign w_hold     = stall_req | (r_valid & ~id_ready);
  assign w_redirect = br_valid & (r_state != S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (fetch_en) w_state_nxt = S_FETCH;
      S_HALT:  if (br_valid) w_state_nxt = S_FLUSH;
      default: begin
        if (br_valid)      w_state_nxt = S_FLUSH;
        else if (w_hold)   w_state_nxt = S_STALL;
        else if (halt_req) w_state_nxt = S_HALT;
        else               w_state_nxt = S_FETCH;
      end
    endcase
  end

  // Output / datapath control decode
  always_comb begin
    w_capture = 1'b0;
    w_drop    = 1'b0;
    // FETCH, STALL (once hold clears) and FLUSH all fetch on a quiet edge.
    if (w_state_nxt == S_FETCH && r_state != S_IDLE)
      w_capture = 1'b1;
    // While halting, the last word leaves IF/ID once decode takes it.
    if (w_state_nxt == S_HALT && r_valid && id_ready)
      w_drop = 1'b1;
  end

  // PC and IF/ID register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_valid <= 1'b0;
      r_ifid  <= '0;
    end else if (w_redirect) begin
      r_pc    <= br_target;
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_ifid  <= {imem_data, r_pc};
      r_valid <= 1'b1;
      r_pc    <= r_pc + ADDR_W'(PC_STEP);
    end else if (w_drop) begin
      r_valid <= 1'b0;
    end
  end

  assign imem_addr  = r_pc;
  assign ifid_valid = r_valid;
  assign ifid_out   = r_ifid;
  assign state_o    = r_state;

`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_state == S_STALL) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_redirect)         r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        br_valid;
  logic [7:0]  br_target;
  logic        stall_req;
  logic        halt_req;
  logic        id_ready;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        ifid_valid;
  logic [23:0] ifid_out;
  logic [2:0]  state_o;
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;

  logic [15:0] mem [256];

  int total;
  int bad;

  // Reference model: what the fetch stage should look like after each edge.
  logic [7:0]  m_pc;
  logic        m_valid;
  logic [23:0] m_out;
  int          m_st;      // 0 idle,1 fetch,2 stall,3 flush,4 halt
  int          m_stalls;
  int          m_flushes;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .br_valid(br_valid),
    .br_target(br_target), .stall_req(stall_req), .halt_req(halt_req),
    .id_ready(id_ready), .imem_addr(imem_addr), .imem_data(imem_data),
    .ifid_valid(ifid_valid), .ifid_out(ifid_out), .state_o(state_o),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_valid = 1'b0; m_out = 24'h0; m_st = 0;
    m_stalls = 0; m_flushes = 0;
  endtask

  // One clock edge of the fetch stage, decided from the rules in priority order.
  task automatic model_edge();
    bit hold;
    hold = stall_req || (m_valid && !id_ready);
    if (m_st == 2 && m_stalls < 65535) m_stalls++;
    if (m_st == 0) begin
      if (fetch_en) m_st = 1;
    end else if (br_valid) begin
      m_pc = br_target; m_valid = 1'b0; m_st = 3;
      if (m_flushes < 65535) m_flushes++;
    end else if (m_st == 4) begin
      if (m_valid && id_ready) m_valid = 1'b0;
    end else if (hold) begin
      m_st = 2;
    end else if (halt_req) begin
      m_st = 4;
      m_valid = 1'b0;   // no hold means decode has taken any valid word
    end else begin
      m_out = {mem[m_pc], m_pc};
      m_valid = 1'b1;
      m_pc = m_pc + 8'd1;
      m_st = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(ifid_valid), 32'(m_valid));
    if (m_valid) chk({tag, ".ifid"}, 32'(ifid_out), 32'(m_out));
    chk({tag, ".addr"}, 32'(imem_addr), 32'(m_pc));
    chk({tag, ".state"}, 32'(state_o), 32'(m_st));
`ifdef FETCH_SEQ_PERF_EN
    chk({tag, ".pstall"}, 32'(perf_stall_cnt), 32'(m_stalls));
    chk({tag, ".pflush"}, 32'(perf_flush_cnt), 32'(m_flushes));
`else
    chk({tag, ".pstall"}, 32'(perf_stall_cnt), 32'h0);
    chk({tag, ".pflush"}, 32'(perf_flush_cnt), 32'h0);
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    fetch_en = 0; br_valid = 0; br_target = 8'h00;
    stall_req = 0; halt_req = 0; id_ready = 1;
  endtask

  initial begin
    logic [7:0] pc_hold;
    total = 0; bad = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h5012; mem[1] = 16'h5052; mem[2] = 16'h5016;
    idle_inputs();
    rst_n = 0;
    model_reset();
    #1;
    chk("rst.valid", 32'(ifid_valid), 32'h0);
    chk("rst.ifid",  32'(ifid_out),   32'h0);
    chk("rst.addr",  32'(imem_addr),  32'h0);
    chk("rst.state", 32'(state_o),    32'h0);
    @(negedge clk);
    rst_n = 1;
    step("idle");

    // Start fetching: first capture is one edge after leaving IDLE.
    fetch_en = 1;
    step("start");
    fetch_en = 0;
    step("f0"); chk("f0.word", 32'(ifid_out), 32'h501200);
    step("f1"); chk("f1.word", 32'(ifid_out), 32'h505201);
    step("f2"); chk("f2.word", 32'(ifid_out), 32'h501602);
    chk("f2.state", 32'(state_o), 32'd1);

    // Decode back-pressure for 3 cycles.
    id_ready = 0;
    for (int i = 0; i < 3; i++) step("bp");
    chk("bp.word", 32'(ifid_out), 32'h501602);
    chk("bp.pc",   32'(imem_addr), 32'h03);
    chk("bp.state", 32'(state_o), 32'd2);
    id_ready = 1;
    step("resume");
    chk("resume.word", 32'(ifid_out), {8'h0, mem[3], 8'h03});

    // Redirect wins over a simultaneous stall.
    br_valid = 1; br_target = 8'h04; stall_req = 1;
    step("br4");
    chk("br4.state", 32'(state_o), 32'd3);
    chk("br4.valid", 32'(ifid_valid), 32'h0);
    br_valid = 0; stall_req = 0;
    step("br4f");
    chk("br4f.word", 32'(ifid_out), {8'h0, mem[4], 8'h04});

    // PC wrap at 0xFF.
    br_valid = 1; br_target = 8'hFF;
    step("brff");
    br_valid = 0;
    step("wrap");
    chk("wrap.pcfield", 32'(ifid_out[7:0]), 32'hFF);
    chk("wrap.next",    32'(imem_addr),     32'h00);

    // Halt, stay frozen, then leave via redirect.
    halt_req = 1;
    step("halt");
    halt_req = 0;
    chk("halt.state", 32'(state_o), 32'd4);
    pc_hold = imem_addr;
    for (int i = 0; i < 10; i++) step("halted");
    chk("halt.frozen", 32'(imem_addr), 32'(pc_hold));
    br_valid = 1; br_target = 8'h10;
    step("br10");
    chk("br10.state", 32'(state_o), 32'd3);
    br_valid = 0;
    step("br10f");
    chk("br10f.word", 32'(ifid_out), {8'h0, mem[16], 8'h10});

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      br_valid  = ($urandom_range(0, 99) < 8);
      br_target = 8'($urandom);
      stall_req = ($urandom_range(0, 99) < 20);
      id_ready  = ($urandom_range(0, 99) < 70);
      halt_req  = ($urandom_range(0, 99) < 3);
      fetch_en  = 1'($urandom);
      step("rnd");
    end

    // Force a stall run, then reset asynchronously in the middle of it.
    idle_inputs();
    br_valid = 1; br_target = 8'h20;
    step("pre");
    br_valid = 0;
    stall_req = 1;
    for (int i = 0; i < 4; i++) step("stl");
    chk("stl.state", 32'(state_o), 32'd2);
    #2;
    rst_n = 0;
    #1;
    chk("arst.valid", 32'(ifid_valid), 32'h0);
    chk("arst.ifid",  32'(ifid_out),   32'h0);
    chk("arst.addr",  32'(imem_addr),  32'h0);
    chk("arst.state", 32'(state_o),    32'h0);
    chk("arst.pstall", 32'(perf_stall_cnt), 32'h0);
    chk("arst.pflush", 32'(perf_flush_cnt), 32'h0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    step("post");
    fetch_en = 1;
    step("post1");
    fetch_en = 0;
    step("post2");
    chk("post2.word", 32'(ifid_out), 32'h501200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
